// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: animates the LED bank one step per rising edge
// of the slow divider output. The four animations are RUN, PINGPONG,
// BAR and BLINK. frame_done pulses for one clk when an animation frame
// completes. Everything runs in the clk domain. step_in is treated as an
// asynchronous level and passes through a two-flop synchroniser before
// its rising edge is detected.
module led_pattern_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             pause,
  output logic [WIDTH-1:0] led,
  output logic             frame_done
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_BIT = ONE << (WIDTH - 1);
  localparam logic [PW-1:0]    LAST    = PW'(WIDTH - 1);
  localparam logic [PW-1:0]    FIRST   = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    PINGPONG = 2'd1,
    BAR      = 2'd2,
    BLINK    = 2'd3
  } mode_e;

  logic             s1_q, s2_q, s3_q;
  logic             active_q, active_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             up_q, up_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             frame_done_q, frame_done_d;

  logic  step;
  mode_e modeIn;

  assign step       = s2_q & ~s3_q;
  assign modeIn     = mode_e'(mode);
  assign led        = led_q;
  assign frame_done = frame_done_q;

  // Synchroniser, rising-edge history and all pattern state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      active_q     <= 1'b0;
      mode_q       <= RUN;
      dir_q        <= 1'b0;
      pos_q        <= '0;
      up_q         <= 1'b1;
      led_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      s1_q         <= step_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      active_q     <= active_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      pos_q        <= pos_d;
      up_q         <= up_d;
      led_q        <= led_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next pattern state: mode entry takes priority over advancing the pattern
  always_comb begin
    active_d     = active_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    pos_d        = pos_q;
    up_d         = up_q;
    led_d        = led_q;
    frame_done_d = 1'b0;

    if (step && !pause) begin
      if (!active_q || modeIn != mode_q) begin
        active_d = 1'b1;
        mode_d   = modeIn;
        dir_d    = dir;
        unique case (modeIn)
          RUN:      led_d = dir ? MSB_BIT : ONE;
          PINGPONG: begin
            pos_d = dir ? LAST : FIRST;
            up_d  = ~dir;
            led_d = ONE << pos_d;
          end
          BAR:      led_d = '0;
          BLINK:    led_d = '1;
        endcase
      end else begin
        unique case (mode_q)
          RUN: begin
            if (dir) begin
              led_d        = {led_q[0], led_q[WIDTH-1:1]};
              frame_done_d = led_q[0];
            end else begin
              led_d        = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
              frame_done_d = led_q[WIDTH-1];
            end
          end
          PINGPONG: begin
            if (up_q) begin
              pos_d = pos_q + 1'b1;
              if (pos_d == LAST) up_d = 1'b0;
            end else begin
              pos_d = pos_q - 1'b1;
              if (pos_d == FIRST) up_d = 1'b1;
            end
            led_d        = ONE << pos_d;
            frame_done_d = (pos_d == (dir_q ? LAST : FIRST));
          end
          BAR: begin
            if (&led_q) begin
              led_d        = '0;
              frame_done_d = 1'b1;
              dir_d        = dir;
            end else if (dir_q) begin
              led_d = (led_q >> 1) | MSB_BIT;
            end else begin
              led_d = (led_q << 1) | ONE;
            end
          end
          BLINK: begin
            led_d        = ~led_q;
            frame_done_d = &led_q;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq at WIDTH=8. A behavioural model
// tracks each pattern as a position or step count within its frame and
// derives the LED image from that. The model is compared with the DUT on
// every falling clock edge. Directed sequences also pin literal LED values
// and frame_done counts.
module tb_led_pattern_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         step_in = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         dir = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] led;
  logic         frame_done;

  int checks = 0;
  int fails = 0;
  int fdCount = 0;

  bit mActive = 1'b0;
  int mMode = 0;
  bit mDir = 1'b0;
  int mIdx = 0;
  int mCount = 0;
  bit mFd = 1'b0;
  bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  led_pattern_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .step_in(step_in),
    .mode(mode),
    .dir(dir),
    .pause(pause),
    .led(led),
    .frame_done(frame_done)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // LED image implied by the model's position within the current frame
  function automatic logic [7:0] modelLed();
    int p;
    int v;
    v = 0;
    if (!mActive) return 8'h00;
    case (mMode)
      0: v = 1 << mIdx;
      1: begin
        p = (mCount <= W - 1) ? mCount : 2 * (W - 1) - mCount;
        v = 1 << (mDir ? (W - 1 - p) : p);
      end
      2: v = mDir ? (((1 << mCount) - 1) << (W - mCount)) : ((1 << mCount) - 1);
      default: v = (mCount == 0) ? 32'hFF : 0;
    endcase
    return v[7:0];
  endfunction

  // One accepted step of the model
  task automatic modelStep();
    if (!mActive || int'(mode) != mMode) begin
      mActive = 1'b1;
      mMode   = int'(mode);
      mDir    = dir;
      mCount  = 0;
      mIdx    = dir ? W - 1 : 0;
    end else begin
      case (mMode)
        0: begin
          if (!dir) begin
            mFd  = (mIdx == W - 1);
            mIdx = (mIdx + 1) % W;
          end else begin
            mFd  = (mIdx == 0);
            mIdx = (mIdx + W - 1) % W;
          end
        end
        1: begin
          mCount = (mCount + 1) % (2 * (W - 1));
          mFd    = (mCount == 0);
        end
        2: begin
          mCount = (mCount + 1) % (W + 1);
          if (mCount == 0) begin
            mFd  = 1'b1;
            mDir = dir;
          end
        end
        default: begin
          mCount = (mCount + 1) % 2;
          mFd    = (mCount == 1);
        end
      endcase
    end
  endtask

  // Model update at each rising clk edge; a step is a sampled 0 then 1, two edges back
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mActive = 1'b0; mMode = 0; mDir = 1'b0; mIdx = 0; mCount = 0;
        mFd = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      end else begin
        mFd = 1'b0;
        if (h2 && !h3 && !pause) modelStep();
        h3 = h2;
        h2 = h1;
        h1 = step_in;
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (led !== modelLed()) begin
        fails++;
        $display("[TB] FAIL cycle-led @%0t: got %h, model %h", $time, led, modelLed());
      end
      checks++;
      if (frame_done !== mFd) begin
        fails++;
        $display("[TB] FAIL cycle-frame_done @%0t: got %b, model %b", $time, frame_done, mFd);
      end
      if (frame_done === 1'b1) fdCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Checks the DUT and the model against the same hand-computed LED value
  task automatic checkLed(input string name, input logic [7:0] exp);
    checkOutput(name, {24'h0, led}, {24'h0, exp});
    checkOutput({name, "-model"}, {24'h0, modelLed()}, {24'h0, exp});
  endtask

  // One rising edge of step_in, held high for highCycles clocks, then low
  task automatic applyStimulus(input int highCycles);
    @(negedge clk);
    step_in = 1'b1;
    repeat (highCycles) @(negedge clk);
    step_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] runExp[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] ppExp[16]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                             8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
  logic [7:0] barUp[10]  = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
  logic [7:0] barDn[9]   = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
  logic [7:0] blinkExp[5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};

  // Directed scenario sequence
  initial begin
    int fdBase;
    repeat (3) @(negedge clk);
    checkOutput("reset-led", {24'h0, led}, 32'h0);
    checkOutput("reset-fd", {31'h0, frame_done}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // RUN left, with the first update pinned to two clocks after sampling
    mode = 2'd0; dir = 1'b0;
    fdBase = fdCount;
    @(negedge clk);
    step_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("latency-k+1", {24'h0, led}, 32'h00);
    @(negedge clk);
    checkOutput("latency-k+2", {24'h0, led}, 32'h01);
    repeat (2) @(negedge clk);
    step_in = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i < 10; i++) begin
      applyStimulus(4);
      checkLed($sformatf("run-%0d", i), runExp[i]);
    end
    checkOutput("run-fd-count", fdCount - fdBase, 1);

    // PINGPONG from the MSB end
    mode = 2'd1; dir = 1'b1;
    fdBase = fdCount;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4);
      checkLed($sformatf("pp-%0d", i), ppExp[i]);
    end
    checkOutput("pp-fd-count", fdCount - fdBase, 1);

    // BAR from the LSB; dir flips before the wrap so the next frame fills from the MSB
    mode = 2'd2; dir = 1'b0;
    fdBase = fdCount;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) dir = 1'b1;
      applyStimulus(4);
      checkLed($sformatf("barup-%0d", i), barUp[i]);
    end
    checkOutput("barup-fd-count", fdCount - fdBase, 1);
    fdBase = fdCount;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4);
      checkLed($sformatf("bardn-%0d", i), barDn[i]);
    end
    checkOutput("bardn-fd-count", fdCount - fdBase, 1);

    // BLINK, then a mid-frame switch back to RUN
    mode = 2'd3; dir = 1'b0;
    fdBase = fdCount;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4);
      checkLed($sformatf("blink-%0d", i), blinkExp[i]);
    end
    checkOutput("blink-fd-count", fdCount - fdBase, 2);
    mode = 2'd0;
    fdBase = fdCount;
    applyStimulus(4);
    checkLed("switch-run", 8'h01);
    checkOutput("switch-fd-count", fdCount - fdBase, 0);

    // Pause holds the pattern with no burst on release; a long high is one step
    for (int i = 0; i < 3; i++) applyStimulus(4);
    checkLed("pre-pause", 8'h08);
    pause = 1'b1;
    fdBase = fdCount;
    for (int i = 0; i < 5; i++) applyStimulus(4);
    checkLed("paused", 8'h08);
    checkOutput("paused-fd-count", fdCount - fdBase, 0);
    pause = 1'b0;
    repeat (3) @(negedge clk);
    checkLed("unpause-no-burst", 8'h08);
    applyStimulus(4);
    checkLed("unpause-step", 8'h10);
    applyStimulus(50);
    checkLed("long-high", 8'h20);

    // Asynchronous reset in the middle of a BAR fill
    mode = 2'd2; dir = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(4);
    checkLed("bar-before-reset", 8'h1F);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async-reset-led", {24'h0, led}, 32'h0);
    checkOutput("async-reset-fd", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    fdBase = fdCount;
    applyStimulus(4);
    checkLed("post-reset-entry", 8'h00);
    applyStimulus(4);
    checkLed("post-reset-first", 8'h01);
    checkOutput("post-reset-fd-count", fdCount - fdBase, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
